// File: rtl/w5300_bus_responder.sv
// Chip-side stand-in for the W5300 16-bit parallel host bus: synchronized strobes,
// small register map, scratch RAM and a loopback FIFO with sticky overflow/underflow flags.
`timescale 1ns/1ps
module w5300_bus_responder #(
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned SCRATCH_WORDS = 32,
  parameter logic [15:0] ID_VALUE      = 16'h5300
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [9:0]                    bus_addr,
  inout  wire  [15:0]                   bus_data,
  input  logic                          cs_n,
  input  logic                          rd_n,
  input  logic                          we_n,
  input  logic                          hw_rst_n,
  output logic                          int_n,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          bus_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = (SCRATCH_WORDS > 1) ? $clog2(SCRATCH_WORDS) : 1;
  localparam logic [PW:0] CNT_FULL = FIFO_DEPTH[PW:0];
  localparam logic [8:0] A_MR = 9'h000, A_IR = 9'h001, A_IMR = 9'h002,
                         A_FIFO = 9'h003, A_LVL = 9'h004, A_IDR = 9'h07F;

  // Synchronizer bit order: {hw_rst_n, we_n, rd_n, cs_n}
  logic [3:0] meta_q, meta_d, s_q, s_d;
  logic [2:0] p_q, p_d;

  logic [15:0] mr_q, mr_d, imr_q, imr_d, rd_q, rd_d, wr_data_q, wr_data_d;
  logic [8:0]  wr_waddr_q, wr_waddr_d;
  logic        wr_valid_q, wr_valid_d, drive_en_q, drive_en_d, bus_err_q, bus_err_d;
  logic        int_n_q, int_n_d, ovf_q, ovf_d, unf_q, unf_d, soft_rst_q, soft_rst_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [15:0] fifo_q [FIFO_DEPTH];
  logic [15:0] fifo_d [FIFO_DEPTH];
  logic [15:0] scr_q [SCRATCH_WORDS];
  logic [15:0] scr_d [SCRATCH_WORDS];

  logic s_cs_n, s_rd_n, s_we_n, s_hw_rst_n, p_cs_n, p_rd_n, p_we_n;
  logic rd_start, illegal, illegal_p, wr_cap, commit, core_rst;
  logic [8:0]  rd_waddr;
  logic [15:0] ir_val;
  logic        unused_addr0;

  assign unused_addr0 = bus_addr[0];
  assign {s_hw_rst_n, s_we_n, s_rd_n, s_cs_n} = s_q;
  assign {p_we_n, p_rd_n, p_cs_n} = p_q;
  assign rd_waddr  = bus_addr[9:1];
  assign rd_start  = !s_cs_n && !s_rd_n && s_we_n && (p_rd_n || p_cs_n);
  assign illegal   = !s_cs_n && !s_rd_n && !s_we_n;
  assign illegal_p = !p_cs_n && !p_rd_n && !p_we_n;
  assign wr_cap    = !s_cs_n && !s_we_n && s_rd_n;
  assign commit    = s_we_n && !p_we_n && !p_cs_n && wr_valid_q;
  assign core_rst  = rst || !s_hw_rst_n || soft_rst_q;
  assign ir_val    = {13'b0, unf_q, ovf_q, (cnt_q != '0)};

  function automatic logic scr_hit(input logic [8:0] wa);
    return (wa[8:7] == 2'b01) && (32'(wa[6:0]) < SCRATCH_WORDS);
  endfunction

  always_comb begin
    meta_d = {hw_rst_n, we_n, rd_n, cs_n};
    s_d    = meta_q;
    p_d    = s_q[2:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '1;
      s_q    <= '1;
      p_q    <= '1;
    end else begin
      meta_q <= meta_d;
      s_q    <= s_d;
      p_q    <= p_d;
    end
  end

  always_comb begin
    mr_d       = mr_q;
    imr_d      = imr_q;
    rd_d       = rd_q;
    wr_data_d  = wr_data_q;
    wr_waddr_d = wr_waddr_q;
    wr_valid_d = wr_valid_q;
    drive_en_d = drive_en_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    fifo_d     = fifo_q;
    scr_d      = scr_q;
    soft_rst_d = 1'b0;
    bus_err_d  = illegal && !illegal_p;
    int_n_d    = ~|(ir_val & imr_q);

    if (wr_cap) begin
      wr_waddr_d = rd_waddr;
      wr_data_d  = bus_data;
      wr_valid_d = 1'b1;
    end
    // A strobe that ever overlapped a read is discarded, not committed on release
    if (illegal) wr_valid_d = 1'b0;

    if (commit) begin
      wr_valid_d = 1'b0;
      case (wr_waddr_q)
        A_MR: begin
          mr_d       = wr_data_q;
          soft_rst_d = wr_data_q[7];
        end
        A_IR: begin
          ovf_d = ovf_q & ~wr_data_q[1];
          unf_d = unf_q & ~wr_data_q[2];
        end
        A_IMR: imr_d = wr_data_q;
        A_FIFO: begin
          if (cnt_q == CNT_FULL) begin
            ovf_d = 1'b1;
          end else begin
            fifo_d[wptr_q] = wr_data_q;
            wptr_d = wptr_q + PW'(1);
            cnt_d  = cnt_d + (PW+1)'(1);
          end
        end
        default: if (scr_hit(wr_waddr_q)) scr_d[wr_waddr_q[SW-1:0]] = wr_data_q;
      endcase
    end

    // Read decode comes after the write so a read-side flag set beats a W1C clear
    if (rd_start) begin
      drive_en_d = 1'b1;
      case (rd_waddr)
        A_MR:  rd_d = mr_q;
        A_IR:  rd_d = ir_val;
        A_IMR: rd_d = imr_q;
        A_FIFO: begin
          if (cnt_q != '0) begin
            rd_d   = fifo_q[rptr_q];
            rptr_d = rptr_q + PW'(1);
            cnt_d  = cnt_d - (PW+1)'(1);
          end else begin
            rd_d  = 16'h0000;
            unf_d = 1'b1;
          end
        end
        A_LVL: rd_d = 16'(cnt_q);
        A_IDR: rd_d = ID_VALUE;
        default: rd_d = scr_hit(rd_waddr) ? scr_q[rd_waddr[SW-1:0]] : 16'h0000;
      endcase
    end
    if (illegal || s_rd_n || s_cs_n) drive_en_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (core_rst) begin
      mr_q       <= '0;
      imr_q      <= '0;
      rd_q       <= '0;
      wr_data_q  <= '0;
      wr_waddr_q <= '0;
      wr_valid_q <= 1'b0;
      drive_en_q <= 1'b0;
      bus_err_q  <= 1'b0;
      int_n_q    <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      soft_rst_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      for (int i = 0; i < SCRATCH_WORDS; i++) scr_q[i] <= '0;
    end else begin
      mr_q       <= mr_d;
      imr_q      <= imr_d;
      rd_q       <= rd_d;
      wr_data_q  <= wr_data_d;
      wr_waddr_q <= wr_waddr_d;
      wr_valid_q <= wr_valid_d;
      drive_en_q <= drive_en_d;
      bus_err_q  <= bus_err_d;
      int_n_q    <= int_n_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      soft_rst_q <= soft_rst_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      fifo_q     <= fifo_d;
      scr_q      <= scr_d;
    end
  end

  assign bus_data   = drive_en_q ? rd_q : 16'bz;
  assign int_n      = int_n_q;
  assign fifo_level = cnt_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_w5300_bus_responder.sv
// Directed bench for w5300_bus_responder; the bus is pulled up, so a released bus reads 16'hFFFF.
`timescale 1ns/1ps
module tb_w5300_bus_responder;

  logic        clk;
  logic        rst;
  logic [9:0]  bus_addr;
  tri1  [15:0] bus_data;
  logic [15:0] tb_drv;
  logic        tb_en;
  logic        cs_n, rd_n, we_n, hw_rst_n;
  logic        int_n;
  logic [3:0]  fifo_level;
  logic        bus_err;
  logic [15:0] rdata;

  int n_pass  = 0;
  int n_total = 0;

  assign bus_data = tb_en ? tb_drv : 16'bz;

  w5300_bus_responder #(
    .FIFO_DEPTH   (8),
    .SCRATCH_WORDS(32),
    .ID_VALUE     (16'h5300)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_addr  (bus_addr),
    .bus_data  (bus_data),
    .cs_n      (cs_n),
    .rd_n      (rd_n),
    .we_n      (we_n),
    .hw_rst_n  (hw_rst_n),
    .int_n     (int_n),
    .fifo_level(fifo_level),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [9:0] a, input logic [15:0] d);
    bus_addr = a;
    tb_drv   = d;
    tb_en    = 1'b1;
    cs_n     = 1'b0;
    we_n     = 1'b0;
    tick(4);
    we_n = 1'b1;
    tick(4);
    cs_n = 1'b1;
    tick(1);
    tb_en = 1'b0;
    tick(3);
  endtask

  task automatic bus_read(input logic [9:0] a, output logic [15:0] d);
    bus_addr = a;
    cs_n     = 1'b0;
    rd_n     = 1'b0;
    tick(3);
    d    = bus_data;
    rd_n = 1'b1;
    cs_n = 1'b1;
    tick(4);
  endtask

  initial begin
    rst = 1'b1; bus_addr = '0; tb_drv = '0; tb_en = 1'b0;
    cs_n = 1'b1; rd_n = 1'b1; we_n = 1'b1; hw_rst_n = 1'b1;
    tick(3);
    chk("rst_int_n", {15'b0, int_n}, 16'h0001);
    chk("rst_fifo_level", {12'b0, fifo_level}, 16'h0000);
    chk("rst_bus_err", {15'b0, bus_err}, 16'h0000);
    chk("rst_bus_released", bus_data, 16'hFFFF);
    rst = 1'b0;
    tick(2);

    // IDR: valid 3 clk after rd_n falls, still driven one clk after sync rise, released the next
    bus_addr = 10'h0FE; cs_n = 1'b0; rd_n = 1'b0;
    tick(3);
    chk("idr_data", bus_data, 16'h5300);
    rd_n = 1'b1; cs_n = 1'b1;
    tick(2);
    chk("idr_hold", bus_data, 16'h5300);
    tick(1);
    chk("idr_release", bus_data, 16'hFFFF);
    tick(2);

    bus_write(10'h100, 16'hA5A5);
    bus_write(10'h13E, 16'hFFFF);
    bus_write(10'h13C, 16'h1234);
    bus_read(10'h100, rdata); chk("scr_first", rdata, 16'hA5A5);
    bus_read(10'h13E, rdata); chk("scr_last", rdata, 16'hFFFF);
    bus_read(10'h13C, rdata); chk("scr_mid", rdata, 16'h1234);
    bus_read(10'h140, rdata); chk("scr_out_of_range", rdata, 16'h0000);

    for (int i = 1; i <= 9; i++) bus_write(10'h006, 16'(i));
    chk("fifo_full_port", {12'b0, fifo_level}, 16'h0008);
    bus_read(10'h008, rdata); chk("fifo_lvl_reg", rdata, 16'h0008);
    bus_read(10'h002, rdata); chk("ir_after_overflow", rdata, 16'h0003);
    for (int i = 1; i <= 8; i++) begin
      bus_read(10'h006, rdata);
      chk($sformatf("pop_%0d", i), rdata, 16'(i));
    end
    chk("fifo_empty_port", {12'b0, fifo_level}, 16'h0000);
    bus_read(10'h006, rdata); chk("pop_empty", rdata, 16'h0000);
    bus_read(10'h002, rdata); chk("ir_after_underflow", rdata, 16'h0006);

    bus_write(10'h004, 16'h0002);
    chk("int_overflow", {15'b0, int_n}, 16'h0000);
    bus_addr = 10'h002; tb_drv = 16'h0002; tb_en = 1'b1; cs_n = 1'b0; we_n = 1'b0;
    tick(4);
    we_n = 1'b1;
    tick(3);
    chk("int_w1c_same_cycle", {15'b0, int_n}, 16'h0000);
    tick(1);
    chk("int_w1c_next_cycle", {15'b0, int_n}, 16'h0001);
    cs_n = 1'b1;
    tick(1);
    tb_en = 1'b0;
    tick(3);
    bus_read(10'h002, rdata); chk("ir_after_w1c", rdata, 16'h0004);

    bus_write(10'h006, 16'h0011);
    bus_write(10'h006, 16'h0022);
    chk("soft_pre_level", {12'b0, fifo_level}, 16'h0002);
    bus_write(10'h004, 16'h0004);
    chk("soft_pre_int", {15'b0, int_n}, 16'h0000);
    bus_write(10'h000, 16'h0080);
    bus_read(10'h000, rdata); chk("soft_mr", rdata, 16'h0000);
    bus_read(10'h004, rdata); chk("soft_imr", rdata, 16'h0000);
    bus_read(10'h002, rdata); chk("soft_ir", rdata, 16'h0000);
    bus_read(10'h008, rdata); chk("soft_lvl", rdata, 16'h0000);
    chk("soft_int_n", {15'b0, int_n}, 16'h0001);

    bus_write(10'h100, 16'h7777);
    bus_write(10'h006, 16'h0033);
    bus_write(10'h004, 16'h0001);
    bus_write(10'h000, 16'h0012);
    bus_read(10'h000, rdata); chk("hw_pre_mr", rdata, 16'h0012);
    chk("hw_pre_int", {15'b0, int_n}, 16'h0000);
    hw_rst_n = 1'b0;
    tick(4);
    hw_rst_n = 1'b1;
    tick(4);
    bus_read(10'h000, rdata); chk("hw_mr", rdata, 16'h0000);
    bus_read(10'h004, rdata); chk("hw_imr", rdata, 16'h0000);
    bus_read(10'h002, rdata); chk("hw_ir", rdata, 16'h0000);
    bus_read(10'h008, rdata); chk("hw_lvl", rdata, 16'h0000);
    bus_read(10'h100, rdata); chk("hw_scratch", rdata, 16'h0000);
    chk("hw_int_n", {15'b0, int_n}, 16'h0001);

    // rd_n and we_n together: one bus_err pulse, bus undriven, scratch untouched
    bus_write(10'h102, 16'h0BEE);
    bus_addr = 10'h102; cs_n = 1'b0; rd_n = 1'b0; we_n = 1'b0;
    tick(3);
    chk("illegal_err_pulse", {15'b0, bus_err}, 16'h0001);
    tick(1);
    chk("illegal_err_single", {15'b0, bus_err}, 16'h0000);
    chk("illegal_no_drive", bus_data, 16'hFFFF);
    rd_n = 1'b1; we_n = 1'b1; cs_n = 1'b1;
    tick(4);
    chk("illegal_no_err_after", {15'b0, bus_err}, 16'h0000);
    bus_read(10'h102, rdata); chk("illegal_no_write", rdata, 16'h0BEE);

    bus_addr = 10'h0FE; cs_n = 1'b0; rd_n = 1'b0;
    tick(3);
    chk("midread_data", bus_data, 16'h5300);
    rst = 1'b1;
    tick(1);
    chk("midread_release", bus_data, 16'hFFFF);
    rd_n = 1'b1; cs_n = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
